// File: rtl/enc32x5_drain_pkg.sv
// Shared sizing and FSM state type for the 32->5 draining priority encoder.
package enc_pkg;

  localparam int N    = 32;
  localparam int IDXW = $clog2(N);
  localparam int CNTW = IDXW + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } enc_state_t;

endpackage

// File: rtl/enc32x5_drain_if.sv
// Request/index handshake bundle for enc32x5_drain; master drives requests, slave is the encoder.
interface enc32x5_drain_if;
  import enc_pkg::*;

  logic [N-1:0]    in_vec;
  logic            in_valid;
  logic            in_ready;
  logic [IDXW-1:0] out_idx;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic [CNTW-1:0] out_cnt;
  logic            zero_pulse;

  modport master (
    output in_vec, in_valid, out_ready,
    input  in_ready, out_idx, out_valid, out_last, out_cnt, zero_pulse
  );

  modport slave (
    input  in_vec, in_valid, out_ready,
    output in_ready, out_idx, out_valid, out_last, out_cnt, zero_pulse
  );

endinterface

// File: rtl/enc32x5_drain_prio_enc32.sv
// Combinational N->IDXW priority encoder with 'any' flag.
// Macro ENC_MSB_FIRST_EN selects highest-index priority; default is lowest-index priority.
module prio_enc32
  import enc_pkg::*;
(
  input  logic [N-1:0]    i_vec,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  // NOTE: every output gets a default first so no path through the loop can infer a latch.
  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
`ifdef ENC_MSB_FIRST_EN
    // Ascending scan: the last hit, i.e. the highest set bit, wins.
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) o_idx = IDXW'(i);
    end
`else
    // Descending scan: the last hit, i.e. the lowest set bit, wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDXW'(i);
    end
`endif
  end

endmodule

// File: rtl/enc32x5_drain.sv
// Sequential 32->5 priority encoder: loads a request vector, then emits one set-bit index per handshake.
// Service order follows prio_enc32 (macro ENC_MSB_FIRST_EN reverses it).
module enc32x5_drain
  import enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  enc32x5_drain_if.slave   bus
);

  enc_state_t      r_state;
  logic [N-1:0]    r_pend;
  logic [CNTW-1:0] r_cnt;
  logic            r_zero_pulse;

  logic [IDXW-1:0] w_idx;
  logic            w_any;
  logic            w_drain;
  logic            w_last;
  logic [N-1:0]    w_clr;

  prio_enc32 u_prio (
    .i_vec (r_pend),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_drain = (r_state == ST_DRAIN);
  // Single pending bit left <=> clearing the lowest set bit leaves nothing.
  assign w_last  = ((r_pend & (r_pend - N'(1))) == '0);
  assign w_clr   = N'(1) << w_idx;

  // NOTE: pend is cleared on reset too, so a reset mid-drain discards every outstanding request.
  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pend       <= '0;
      r_cnt        <= '0;
      r_zero_pulse <= 1'b0;
    end else begin
      r_zero_pulse <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (bus.in_valid) begin
          r_pend <= bus.in_vec;
          r_cnt  <= '0;
          if (bus.in_vec == '0) r_zero_pulse <= 1'b1;
          else                  r_state      <= ST_DRAIN;
        end
      end else if (bus.out_ready) begin
        r_pend <= r_pend & ~w_clr;
        r_cnt  <= r_cnt + CNTW'(1);
        if (w_last) r_state <= ST_IDLE;
      end
    end
  end

  assign bus.in_ready   = (r_state == ST_IDLE);
  assign bus.out_valid  = w_drain;
  assign bus.out_idx    = (w_drain && w_any) ? w_idx : '0;
  assign bus.out_last   = w_drain & w_any & w_last;
  assign bus.out_cnt    = r_cnt;
  assign bus.zero_pulse = r_zero_pulse;

endmodule

// File: tb/tb_enc32x5_drain.sv
// Self-checking bench for enc32x5_drain: directed cases pinned by literals plus a randomized run
// compared every cycle against a queue-based model of the draining order.
module tb_enc32x5_drain;
  import enc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  enc32x5_drain_if bus ();

  enc32x5_drain dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pending indices in service order, served count, zero pulse.
  bit          m_busy;
  int          m_q[$];
  int unsigned m_cnt;
  bit          m_zp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_q.delete();
    m_cnt  = 0;
    m_zp   = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] vec, input logic rdy);
    m_zp = 1'b0;
    if (!m_busy) begin
      if (v) begin
        m_cnt = 0;
        if (vec == 32'h0) m_zp = 1'b1;
        else begin
          m_q.delete();
          for (int i = 0; i < 32; i++) begin
            if (vec[i]) begin
`ifdef ENC_MSB_FIRST_EN
              m_q.push_front(i);
`else
              m_q.push_back(i);
`endif
            end
          end
          m_busy = 1'b1;
        end
      end
    end else if (rdy) begin
      void'(m_q.pop_front());
      m_cnt = (m_cnt + 1) % 64;
      if (m_q.size() == 0) m_busy = 1'b0;
    end
  endtask

  task automatic tick(input logic v, input logic [31:0] vec, input logic rdy);
    bus.in_valid  = v;
    bus.in_vec    = vec;
    bus.out_ready = rdy;
    @(posedge clk);
    model_step(v, vec, rdy);
    #1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready",   32'(bus.in_ready),   32'(!m_busy));
      check("out_valid",  32'(bus.out_valid),  32'(m_busy));
      check("out_idx",    32'(bus.out_idx),    m_busy ? 32'(m_q[0]) : 32'h0);
      check("out_last",   32'(bus.out_last),   32'(m_busy && m_q.size() == 1));
      check("out_cnt",    32'(bus.out_cnt),    32'(m_cnt));
      check("zero_pulse", 32'(bus.zero_pulse), 32'(m_zp));
    end
  end

  int exp1[3];
  logic [31:0] rv;
  logic [31:0] bit_val;

  initial begin
`ifdef ENC_MSB_FIRST_EN
    exp1 = '{31, 4, 0};
`else
    exp1 = '{0, 4, 31};
`endif
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",   32'(bus.in_ready),   32'h1);
    check("rst_out_valid",  32'(bus.out_valid),  32'h0);
    check("rst_out_idx",    32'(bus.out_idx),    32'h0);
    check("rst_out_last",   32'(bus.out_last),   32'h0);
    check("rst_out_cnt",    32'(bus.out_cnt),    32'h0);
    check("rst_zero_pulse", 32'(bus.zero_pulse), 32'h0);
    rst_n = 1'b1;

    // Three set bits, continuous ready.
    tick(1'b1, 32'h8000_0011, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("t1_idx",  32'(bus.out_idx),  32'(exp1[i]));
      check("t1_last", 32'(bus.out_last), 32'(i == 2));
      tick(1'b0, 32'h0, 1'b1);
    end
    check("t1_in_ready", 32'(bus.in_ready), 32'h1);

    // Backpressure holds the first index and the count.
    tick(1'b1, 32'h0000_0006, 1'b0);
    for (int i = 0; i < 3; i++) begin
`ifdef ENC_MSB_FIRST_EN
      check("t2_hold_idx", 32'(bus.out_idx), 32'd2);
`else
      check("t2_hold_idx", 32'(bus.out_idx), 32'd1);
`endif
      check("t2_hold_cnt", 32'(bus.out_cnt), 32'd0);
      tick(1'b0, 32'h0, 1'b0);
    end
    tick(1'b0, 32'h0, 1'b1);
`ifdef ENC_MSB_FIRST_EN
    check("t2_idx2", 32'(bus.out_idx), 32'd1);
`else
    check("t2_idx2", 32'(bus.out_idx), 32'd2);
`endif
    check("t2_last", 32'(bus.out_last), 32'h1);
    check("t2_cnt1", 32'(bus.out_cnt),  32'd1);
    tick(1'b0, 32'h0, 1'b1);
    check("t2_cnt2", 32'(bus.out_cnt), 32'd2);

    // All-zero vector: one pulse, no output.
    tick(1'b1, 32'h0, 1'b1);
    check("t3_pulse",    32'(bus.zero_pulse), 32'h1);
    check("t3_valid",    32'(bus.out_valid),  32'h0);
    check("t3_in_ready", 32'(bus.in_ready),   32'h1);
    tick(1'b0, 32'h0, 1'b1);
    check("t3_pulse_off", 32'(bus.zero_pulse), 32'h0);

    // All-ones vector: 32 handshakes.
    tick(1'b1, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 32; i++) begin
`ifdef ENC_MSB_FIRST_EN
      check("t4_idx", 32'(bus.out_idx), 32'(31 - i));
`else
      check("t4_idx", 32'(bus.out_idx), 32'(i));
`endif
      check("t4_cnt",  32'(bus.out_cnt),  32'(i));
      check("t4_last", 32'(bus.out_last), 32'(i == 31));
      tick(1'b0, 32'h0, 1'b1);
    end
    check("t4_cnt_final", 32'(bus.out_cnt),  32'd32);
    check("t4_in_ready",  32'(bus.in_ready), 32'h1);

    // Reset in the middle of a drain.
    tick(1'b1, 32'h0000_F000, 1'b1);
    tick(1'b0, 32'h0, 1'b1);
    tick(1'b0, 32'h0, 1'b1);
`ifdef ENC_MSB_FIRST_EN
    check("t5_idx_pre", 32'(bus.out_idx), 32'd13);
`else
    check("t5_idx_pre", 32'(bus.out_idx), 32'd14);
`endif
    check("t5_cnt_pre", 32'(bus.out_cnt), 32'd2);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t5_valid",    32'(bus.out_valid), 32'h0);
    check("t5_in_ready", 32'(bus.in_ready),  32'h1);
    check("t5_idx",      32'(bus.out_idx),   32'h0);
    check("t5_cnt",      32'(bus.out_cnt),   32'h0);
    rst_n = 1'b1;
    tick(1'b1, 32'h0000_0300, 1'b1);
`ifdef ENC_MSB_FIRST_EN
    check("t5_new_idx", 32'(bus.out_idx), 32'd9);
`else
    check("t5_new_idx", 32'(bus.out_idx), 32'd8);
`endif
    tick(1'b0, 32'h0, 1'b1);
    check("t5_new_last", 32'(bus.out_last), 32'h1);
    tick(1'b0, 32'h0, 1'b1);

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(4, 0))
        0:       rv = 32'h0;
        1: begin
          bit_val = 32'h1;
          rv = bit_val << $urandom_range(31, 0);
        end
        2:       rv = $urandom;
        3:       rv = $urandom & $urandom & $urandom;
        default: rv = 32'hFFFF_FFFF;
      endcase
      tick(1'($urandom_range(1, 0)), rv, 1'($urandom_range(9, 0) < 7));
    end
    tick(1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
